// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential 14-bit binary to 4-digit BCD converter, one double-dabble step per clock
// Inputs above 9999 are clamped to 9999 and flagged on ovf.
module bin2bcd_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [13:0] bin,
    output logic        ready,
    output logic        done,
    output logic [3:0]  bcd0,
    output logic [3:0]  bcd1,
    output logic [3:0]  bcd2,
    output logic [3:0]  bcd3,
    output logic        ovf
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [13:0] bin_reg;
    logic [15:0] scratch;
    logic [15:0] adj;
    logic [29:0] shifted;
    logic [3:0]  cnt;
    logic        ovf_flag;

    // Per-digit add-3 correction, then a single left shift of {scratch, bin_reg}
    always_comb begin
        adj = scratch;
        for (int i = 0; i < 4; i++) begin
            if (scratch[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
        end
        shifted = {adj, bin_reg} << 1;
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start)
                    state_nxt = SHIFT;
            end
            SHIFT: begin
                if (cnt == 4'd13)
                    state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            bin_reg  <= '0;
            scratch  <= '0;
            cnt      <= '0;
            ovf_flag <= 1'b0;
            bcd0     <= '0;
            bcd1     <= '0;
            bcd2     <= '0;
            bcd3     <= '0;
            ovf      <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        bin_reg  <= (bin > 14'd9999) ? 14'd9999 : bin;
                        ovf_flag <= (bin > 14'd9999);
                        scratch  <= '0;
                        cnt      <= '0;
                    end
                end
                SHIFT: begin
                    scratch <= shifted[29:14];
                    bin_reg <= shifted[13:0];
                    cnt     <= cnt + 4'd1;
                    // Visible outputs only move once the final digits are formed
                    if (cnt == 4'd13) begin
                        bcd0 <= shifted[17:14];
                        bcd1 <= shifted[21:18];
                        bcd2 <= shifted[25:22];
                        bcd3 <= shifted[29:26];
                        ovf  <= ovf_flag;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - self-checking bench for bin2bcd_seq with a cycle-level behavioural model
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [13:0] bin = '0;
    logic        ready, done, ovf;
    logic [3:0]  bcd0, bcd1, bcd2, bcd3;

    int vectors = 0;
    int miscompares = 0;
    int done_cnt = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    bin2bcd_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (bin),
        .ready (ready),
        .done  (done),
        .bcd0  (bcd0),
        .bcd1  (bcd1),
        .bcd2  (bcd2),
        .bcd3  (bcd3),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    // Model: phase counts edges since accept (0 = idle); result appears 14 edges after accept
    int          m_phase = 0;
    int          m_val = 0;
    logic [15:0] m_digits = '0;
    logic        m_ovf = 1'b0;

    always @(posedge clk) begin
        int v;
        cyc = cyc + 1;
        if (rst) begin
            m_phase  = 0;
            m_digits = '0;
            m_ovf    = 1'b0;
        end else if (m_phase == 0) begin
            if (start) begin
                m_val   = int'(bin);
                m_phase = 1;
            end
        end else begin
            m_phase = m_phase + 1;
            if (m_phase == 15) begin
                v = (m_val > 9999) ? 9999 : m_val;
                m_digits = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
                m_ovf    = (m_val > 9999);
            end
            if (m_phase == 16)
                m_phase = 0;
        end
    end

    always @(negedge clk) begin
        logic [18:0] got, exp;
        if (done)
            done_cnt = done_cnt + 1;
        if (chk_en) begin
            got = {ready, done, ovf, bcd3, bcd2, bcd1, bcd0};
            exp = {(m_phase == 0), (m_phase == 15), m_ovf, m_digits};
            vectors = vectors + 1;
            if (got !== exp) begin
                miscompares = miscompares + 1;
                $display("FAIL model_cmp cycle %0d got %h expected %h", cyc, got, exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors = vectors + 1;
        if (act !== expv) begin
            miscompares = miscompares + 1;
            $display("FAIL %s got %h expected %h", name, act, expv);
        end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        if (done !== 1'b1) begin
            vectors = vectors + 1;
            miscompares = miscompares + 1;
            $display("FAIL done_timeout got no done expected done within 40 cycles");
        end
    endtask

    task automatic convert(input logic [13:0] v, output int lat);
        bin   = v;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(lat);
    endtask

    task automatic check_result(input string name, input logic [15:0] dig, input logic o);
        check(name, {15'd0, ovf, bcd3, bcd2, bcd1, bcd0}, {15'd0, o, dig});
    endtask

    logic [13:0] hold_vals [7] = '{14'd0, 14'd1, 14'd99, 14'd100, 14'd999, 14'd1000, 14'd9998};
    logic [15:0] hold_exp  [7] = '{16'h0000, 16'h0001, 16'h0099, 16'h0100, 16'h0999, 16'h1000, 16'h9998};

    initial begin
        int lat, d0, prev_cyc;
        rst = 1'b1;
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        check("reset_ready", 32'(ready), 32'd1);
        check("reset_done", 32'(done), 32'd0);
        check_result("reset_digits", 16'h0000, 1'b0);

        convert(14'd0, lat);
        check("latency_0", 32'(lat), 32'd14);
        check_result("conv_0", 16'h0000, 1'b0);
        tick();
        check("ready_after_done", 32'(ready), 32'd1);
        check("done_one_cycle", 32'(done), 32'd0);

        convert(14'd1234, lat);  check_result("conv_1234", 16'h1234, 1'b0);  tick();
        convert(14'd9999, lat);  check_result("conv_9999", 16'h9999, 1'b0);  tick();
        convert(14'd10, lat);    check_result("conv_10", 16'h0010, 1'b0);    tick();
        convert(14'd10000, lat); check_result("conv_10000", 16'h9999, 1'b1); tick();
        convert(14'd16383, lat); check_result("conv_16383", 16'h9999, 1'b1); tick();
        convert(14'd42, lat);    check_result("conv_42", 16'h0042, 1'b0);    tick();

        // Requests during SHIFT and DONE are dropped
        d0 = done_cnt;
        bin = 14'd5678; start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        bin = 14'd1111; start = 1'b1; tick(); start = 1'b0;
        repeat (11) tick();
        check("busy_done_e14", 32'(done), 32'd1);
        start = 1'b1; tick(); start = 1'b0;
        tick();
        check("busy_ready_e16", 32'(ready), 32'd1);
        check_result("conv_5678", 16'h5678, 1'b0);
        repeat (20) tick();
        check("busy_one_done", 32'(done_cnt - d0), 32'd1);

        // Reset mid-conversion aborts without a done pulse
        convert(14'd4321, lat); check_result("conv_4321", 16'h4321, 1'b0); tick();
        d0 = done_cnt;
        bin = 14'd8765; start = 1'b1; tick(); start = 1'b0;
        repeat (6) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        check("abort_ready", 32'(ready), 32'd1);
        check_result("abort_digits", 16'h0000, 1'b0);
        repeat (20) tick();
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        convert(14'd1000, lat); check_result("conv_1000", 16'h1000, 1'b0); tick();

        // start held high: back-to-back conversions every 16 cycles
        prev_cyc = 0;
        start = 1'b1;
        for (int i = 0; i < 7; i++) begin
            bin = hold_vals[i];
            tick();
            if (i == 6)
                start = 1'b0;
            check("hold_accept", 32'(ready), 32'd0);
            wait_done(lat);
            check_result("hold_result", hold_exp[i], 1'b0);
            if (i > 0)
                check("hold_interval", 32'(cyc - prev_cyc), 32'd16);
            prev_cyc = cyc;
            tick();
        end
        repeat (20) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
